// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder beside dmem: a TX FIFO, an RX holding register and a free-running
// cycle counter, read back with the same one-edge latency as dmem.
module mmio_responder #(
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 'hF00,
    parameter int unsigned       FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic              sel_q,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_CYCLE  = 2'd2,
        REG_RXDATA = 2'd3
    } reg_e;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              rx_full_q, rx_full_d;
    logic [DATA_W-1:0] rx_reg_q, rx_reg_d;
    logic [DATA_W-1:0] cycle_q, cycle_d;
    logic [DATA_W-1:0] q_d;
    logic              sel_d;

    logic [ADDR_W-1:0] offset;
    logic              is_mmio, in_map, wr_en;
    logic              wr_tx, wr_status, wr_cycle, wr_rx;
    logic              tx_full, tx_empty, push, pop;
    reg_e              reg_sel;
    logic [DATA_W-1:0] status, rdata;

    always_comb begin
        offset    = address - MMIO_BASE;
        is_mmio   = (address >= MMIO_BASE);
        in_map    = is_mmio && (offset < ADDR_W'(4));
        reg_sel   = reg_e'(offset[1:0]);
        wr_en     = wren && in_map;
        wr_tx     = wr_en && (reg_sel == REG_TXDATA);
        wr_status = wr_en && (reg_sel == REG_STATUS);
        wr_cycle  = wr_en && (reg_sel == REG_CYCLE);
        wr_rx     = wr_en && (reg_sel == REG_RXDATA);

        tx_full  = (count_q == FULL_CNT);
        tx_empty = (count_q == '0);
        pop      = !tx_empty && tx_ready;
        // A push into a full FIFO still lands when the head leaves on the same edge.
        push     = wr_tx && (!tx_full || pop);

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q;
        if (wr_status && data[6])
            ovf_d = 1'b0;
        if (wr_tx && tx_full && !pop)
            ovf_d = 1'b1;

        rx_reg_d  = rx_reg_q;
        rx_full_d = rx_full_q;
        if (rx_valid && !rx_full_q) begin
            rx_reg_d  = rx_data;
            rx_full_d = 1'b1;
        end else if (wr_rx) begin
            rx_full_d = 1'b0;
        end

        cycle_d = wr_cycle ? data : cycle_q + DATA_W'(1);

        status      = '0;
        status[7:0] = {rx_full_q, ovf_q, tx_empty, tx_full, 4'(count_q)};
        case (reg_sel)
            REG_STATUS: rdata = status;
            REG_CYCLE:  rdata = cycle_q;
            REG_RXDATA: rdata = rx_reg_q;
            default:    rdata = '0;
        endcase
        q_d   = in_map ? rdata : '0;
        sel_d = is_mmio;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rx_full_q <= 1'b0;
            rx_reg_q  <= '0;
            cycle_q   <= '0;
            q         <= '0;
            sel_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rx_full_q <= rx_full_d;
            rx_reg_q  <= rx_reg_d;
            cycle_q   <= cycle_d;
            q         <= q_d;
            sel_q     <= sel_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign tx_valid = !tx_empty;
    assign tx_data  = mem_q[rd_ptr_q];
    assign rx_ready = !rx_full_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: a fixed vector table, directed corner sequences and a random run,
// all checked against a queue-based model of the register map.
module tb_mmio_responder;

    logic        clock, reset;
    logic [11:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic        sel_q;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready;

    mmio_responder #(
        .ADDR_W    (12),
        .DATA_W    (32),
        .MMIO_BASE (12'hF00),
        .FIFO_DEPTH(8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .sel_q   (sel_q),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ready(rx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: FIFO as a queue, registers as plain variables.
    logic [31:0] m_fifo[$];
    bit          m_ovf, m_rxf, m_sel;
    logic [31:0] m_rx, m_cyc, m_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf = 0; m_rxf = 0; m_sel = 0;
        m_rx = '0; m_cyc = '0; m_q = '0;
    endtask

    task automatic model_edge();
        logic [31:0] rd;
        bit mmio, pop, full;
        int off, sz;
        rd   = '0;
        mmio = (address >= 12'hF00);
        off  = int'(address) - 'hF00;
        sz   = m_fifo.size();
        if (mmio) begin
            case (off)
                1: rd = {24'b0, m_rxf, m_ovf, sz == 0, sz == 8, 4'(sz)};
                2: rd = m_cyc;
                3: rd = m_rx;
                default: rd = '0;
            endcase
        end
        pop  = (sz > 0) && tx_ready;
        full = (sz == 8);
        if (pop) void'(m_fifo.pop_front());
        if (mmio && wren && off == 0) begin
            if (!full || pop) m_fifo.push_back(data);
            else m_ovf = 1;
        end
        if (mmio && wren && off == 1 && data[6]) m_ovf = 0;
        if (rx_valid && !m_rxf) begin
            m_rx = rx_data; m_rxf = 1;
        end else if (mmio && wren && off == 3) begin
            m_rxf = 0;
        end
        m_cyc = (mmio && wren && off == 2) ? data : m_cyc + 1;
        m_q   = rd;
        m_sel = mmio;
    endtask

    task automatic compare_model();
        chk("q", q, m_q);
        chk("sel_q", 32'(sel_q), 32'(m_sel));
        chk("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) chk("tx_data", tx_data, m_fifo[0]);
        chk("rx_ready", 32'(rx_ready), 32'(!m_rxf));
    endtask

    task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w,
                        input logic tr, input logic rv, input logic [31:0] rxd);
        address = a; data = d; wren = w; tx_ready = tr; rx_valid = rv; rx_data = rxd;
        @(posedge clock);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic rd_reg(input logic [11:0] a);
        step(a, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wr_reg(input logic [11:0] a, input logic [31:0] d);
        step(a, d, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q"}, q, 32'h0);
        chk({tag, "_sel_q"}, 32'(sel_q), 32'h0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
        chk({tag, "_tx_data"}, tx_data, 32'h0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b1; wren = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic        wren;
        logic [31:0] exp_q;
        logic        exp_sel;
    } vec_t;

    vec_t tbl[14];

    initial begin
        reset = 1'b1; address = '0; data = '0; wren = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        model_reset();

        // Cycle counter after reset, TX pushes, status, dmem-side writes, CYCLE load, RX empty.
        tbl[0]  = '{12'h010, 32'h0,   1'b0, 32'h0,   1'b0};
        tbl[1]  = '{12'hF02, 32'h0,   1'b0, 32'h1,   1'b1};
        tbl[2]  = '{12'hF02, 32'h0,   1'b0, 32'h2,   1'b1};
        tbl[3]  = '{12'hF02, 32'h0,   1'b0, 32'h3,   1'b1};
        tbl[4]  = '{12'hF00, 32'hA,   1'b1, 32'h0,   1'b1};
        tbl[5]  = '{12'hF00, 32'hB,   1'b1, 32'h0,   1'b1};
        tbl[6]  = '{12'hF00, 32'hC,   1'b1, 32'h0,   1'b1};
        tbl[7]  = '{12'hF01, 32'h0,   1'b0, 32'h03,  1'b1};
        tbl[8]  = '{12'hF05, 32'h0,   1'b0, 32'h0,   1'b1};
        tbl[9]  = '{12'h100, 32'h77,  1'b1, 32'h0,   1'b0};
        tbl[10] = '{12'hF01, 32'h0,   1'b0, 32'h03,  1'b1};
        tbl[11] = '{12'hF02, 32'h100, 1'b1, 32'hB,   1'b1};
        tbl[12] = '{12'hF02, 32'h0,   1'b0, 32'h100, 1'b1};
        tbl[13] = '{12'hF03, 32'h0,   1'b0, 32'h0,   1'b1};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].addr, tbl[i].data, tbl[i].wren, 1'b0, 1'b0, '0);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
            chk($sformatf("tbl%0d_sel", i), 32'(sel_q), 32'(tbl[i].exp_sel));
        end

        // Drain A,B,C one per edge.
        chk("drain_head0", tx_data, 32'hA);
        step(12'h010, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("drain_head1", tx_data, 32'hB);
        step(12'h010, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("drain_head2", tx_data, 32'hC);
        step(12'h010, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("drain_empty", 32'(tx_valid), 32'h0);
        rd_reg(12'hF01);
        chk("drain_status", q, 32'h20);

        // Overflow: ninth word dropped, ovf sticky until cleared.
        for (int i = 0; i < 9; i++) wr_reg(12'hF00, 32'h100 + 32'(i));
        rd_reg(12'hF01);
        chk("ovf_status", q, 32'h58);
        wr_reg(12'hF01, 32'h40);
        rd_reg(12'hF01);
        chk("ovf_cleared", q, 32'h18);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_head%0d", i), tx_data, 32'h100 + 32'(i));
            step(12'h010, '0, 1'b0, 1'b1, 1'b0, '0);
        end
        chk("ovf_drained", 32'(tx_valid), 32'h0);

        // Full FIFO: push and pop on the same edge.
        for (int i = 0; i < 8; i++) wr_reg(12'hF00, 32'h200 + 32'(i));
        step(12'hF00, 32'h2FF, 1'b1, 1'b1, 1'b0, '0);
        rd_reg(12'hF01);
        chk("fullpp_status", q, 32'h18);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullpp_head%0d", i), tx_data, (i == 7) ? 32'h2FF : 32'h201 + 32'(i));
            step(12'h010, '0, 1'b0, 1'b1, 1'b0, '0);
        end
        chk("fullpp_drained", 32'(tx_valid), 32'h0);

        // RX holding register and back-pressure.
        step(12'h010, '0, 1'b0, 1'b0, 1'b1, 32'h1234);
        chk("rx_ready_low", 32'(rx_ready), 32'h0);
        step(12'hF03, '0, 1'b0, 1'b0, 1'b1, 32'h5678);
        chk("rx_read1", q, 32'h1234);
        step(12'hF03, '0, 1'b0, 1'b0, 1'b1, 32'h5678);
        chk("rx_read2", q, 32'h1234);
        step(12'hF03, '0, 1'b1, 1'b0, 1'b1, 32'h5678);
        chk("rx_ready_high", 32'(rx_ready), 32'h1);
        step(12'hF03, '0, 1'b0, 1'b0, 1'b1, 32'h9ABC);
        chk("rx_old_value", q, 32'h1234);
        rd_reg(12'hF03);
        chk("rx_next_word", q, 32'h9ABC);
        wr_reg(12'hF03, '0);

        // Counter wrap, then reset in the middle of a push burst.
        for (int i = 0; i < 3; i++) wr_reg(12'hF00, 32'h300 + 32'(i));
        wr_reg(12'hF02, 32'hFFFF_FFFE);
        rd_reg(12'hF02);
        chk("wrap0", q, 32'hFFFF_FFFE);
        rd_reg(12'hF02);
        chk("wrap1", q, 32'hFFFF_FFFF);
        rd_reg(12'hF02);
        chk("wrap2", q, 32'h0);
        wr_reg(12'hF00, 32'h303);
        address = 12'hF00; data = 32'h304; wren = 1'b1;
        #3;
        do_reset();
        rd_reg(12'hF02);
        chk("post_reset_cycle", q, 32'h0);
        rd_reg(12'hF01);
        chk("post_reset_status", q, 32'h20);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [11:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 8) a = 12'hF00 + 12'(sel);
            else if (sel == 8) a = 12'hFFF;
            else a = 12'($urandom_range(0, 12'hEFF));
            step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
